// File: rtl/pe_pkg.sv
// Shared types, default sizes and the saturating accumulate helper for the vector PE.
package pe_pkg;

  localparam int unsigned DefLanes = 4;
  localparam int unsigned DefDw    = 8;
  localparam int unsigned DefAccW  = 32;
  localparam int unsigned DefCntW  = 16;

  typedef logic signed [DefDw-1:0]   operand_t;
  typedef logic signed [DefAccW-1:0] acc_t;

  // Adds prod to acc and range-checks the sum against a signed acc_w-bit accumulator.
  // Returns {ovf, result}; the caller keeps the low acc_w bits, which gives wrap when
  // sat_en is low and the clamped bound when it is high. Supports acc_w up to 63.
  function automatic logic [64:0] sat_add(input logic signed [63:0] acc,
                                          input logic signed [63:0] prod,
                                          input int unsigned        acc_w,
                                          input logic               sat_en);
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] res;
    logic               ovf;
    sum   = acc + prod;
    max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    ovf   = (sum > max_v) || (sum < min_v);
    res   = sum;
    if (ovf && sat_en) begin
      res = (sum > max_v) ? max_v : min_v;
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/pe_vec_if.sv
// Operand stream, weight-load controls, forwarded copies and results of one vector PE.
interface pe_vec_if
  import pe_pkg::*;
#(
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned CNT_W = DefCntW
);
  logic [LANES*DW-1:0]    a_in;
  logic                   a_valid;
  logic [LANES*DW-1:0]    b_in;
  logic                   load_weight;
  logic                   swap_weight;
  logic                   clr;
  logic [LANES*DW-1:0]    a_out;
  logic                   a_valid_out;
  logic                   load_weight_out;
  logic                   swap_weight_out;
  logic [LANES*ACC_W-1:0] acc;
  logic [LANES-1:0]       sat_flag;
  logic [CNT_W-1:0]       beat_cnt;

  modport master (
    output a_in, a_valid, b_in, load_weight, swap_weight, clr,
    input  a_out, a_valid_out, load_weight_out, swap_weight_out, acc, sat_flag, beat_cnt
  );

  modport slave (
    input  a_in, a_valid, b_in, load_weight, swap_weight, clr,
    output a_out, a_valid_out, load_weight_out, swap_weight_out, acc, sat_flag, beat_cnt
  );
endinterface

// File: rtl/pe_mac_lane.sv
// One MAC lane: shadow/active weights, multiplier, optional product register,
// saturating or wrapping accumulator and sticky overflow flag.
module pe_mac_lane
  import pe_pkg::*;
#(
  parameter int unsigned DW    = DefDw,
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned PIPE  = 1,
  parameter int unsigned SAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  input  logic                    load_weight,
  input  logic                    swap_weight,
  input  logic                    clr,
  input  logic                    acc_en,
  output logic signed [ACC_W-1:0] acc,
  output logic                    sat_flag
);

  logic signed [DW-1:0]    shadow_q;
  logic signed [DW-1:0]    active_q;
  logic signed [2*DW-1:0]  prod_c;
  logic signed [2*DW-1:0]  prod_s;
  logic signed [ACC_W-1:0] acc_q;
  logic                    sat_q;
  logic                    ovf;
  logic signed [63:0]      sum_w;
  logic                    unused_sum_hi;

  assign prod_c = a * active_q;

  // Weight banks: swap copies the pre-edge shadow, so load+swap together is well defined
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (load_weight) shadow_q <= b;
      if (swap_weight) active_q <= shadow_q;
    end
  end

  if (PIPE != 0) begin : g_pipe
    logic signed [2*DW-1:0] prod_q;
    // Product register; the weight is bound at issue, so later swaps cannot touch it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prod_q <= '0;
      else        prod_q <= prod_c;
    end
    assign prod_s = prod_q;
  end else begin : g_comb
    assign prod_s = prod_c;
  end

  assign {ovf, sum_w}  = sat_add(64'(acc_q), 64'(prod_s), ACC_W, SAT != 0);
  assign unused_sum_hi = ^sum_w[63:ACC_W];

  // Accumulator and sticky flag; clr beats any landing product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (acc_en) begin
      acc_q <= sum_w[ACC_W-1:0];
      if (ovf) sat_q <= 1'b1;
    end
  end

  assign acc      = acc_q;
  assign sat_flag = sat_q;

endmodule

// File: rtl/pe_vec.sv
// Vector systolic PE: LANES MAC lanes sharing one activation stream, with
// one-hop forwarding of activations and weight controls and a beat counter.
module pe_vec
  import pe_pkg::*;
#(
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned PIPE  = 1,
  parameter int unsigned SAT   = 1,
  parameter int unsigned CNT_W = DefCntW
) (
  input logic     clk,
  input logic     rst_n,
  pe_vec_if.slave bus
);

  logic [LANES*DW-1:0]           a_out_q;
  logic                          a_valid_q;
  logic                          load_q;
  logic                          swap_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          acc_en;
  logic [LANES-1:0][ACC_W-1:0]   acc_v;
  logic [LANES-1:0]              sat_v;

  // Forward activations and weight controls one hop, ungated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out_q   <= '0;
      a_valid_q <= 1'b0;
      load_q    <= 1'b0;
      swap_q    <= 1'b0;
    end else begin
      a_out_q   <= bus.a_in;
      a_valid_q <= bus.a_valid;
      load_q    <= bus.load_weight;
      swap_q    <= bus.swap_weight;
    end
  end

  if (PIPE != 0) begin : g_pv
    logic pv_q;
    // Valid bit of the product stage; a beat issued alongside clr never enters it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pv_q <= 1'b0;
      else        pv_q <= bus.a_valid & ~bus.clr;
    end
    assign acc_en = pv_q;
  end else begin : g_nopv
    assign acc_en = bus.a_valid;
  end

  // Count accumulated beats, holding at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.clr) begin
      cnt_q <= '0;
    end else if (acc_en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_mac_lane #(
      .DW    (DW),
      .ACC_W (ACC_W),
      .PIPE  (PIPE),
      .SAT   (SAT)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (bus.a_in[i*DW +: DW]),
      .b           (bus.b_in[i*DW +: DW]),
      .load_weight (bus.load_weight),
      .swap_weight (bus.swap_weight),
      .clr         (bus.clr),
      .acc_en      (acc_en),
      .acc         (acc_v[i]),
      .sat_flag    (sat_v[i])
    );
  end

  assign bus.a_out           = a_out_q;
  assign bus.a_valid_out     = a_valid_q;
  assign bus.load_weight_out = load_q;
  assign bus.swap_weight_out = swap_q;
  assign bus.acc             = acc_v;
  assign bus.sat_flag        = sat_v;
  assign bus.beat_cnt        = cnt_q;

endmodule

// File: tb/tb_pe_vec.sv
// Bench for pe_vec: three instances (32-bit sat, 20-bit sat, 20-bit wrap) share one
// input stream; a reference model pushes one expected snapshot per edge and a monitor
// compares every instance against it on the falling edge.
module tb_pe_vec;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pe_vec_if                bus0 ();
  pe_vec_if #(.ACC_W(20))  bus1 ();
  pe_vec_if #(.ACC_W(20))  bus2 ();

  pe_vec                         u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pe_vec #(.ACC_W(20), .SAT(1))  u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pe_vec #(.ACC_W(20), .SAT(0))  u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [31:0] a_in_r, b_in_r;
  logic        av_r, lw_r, sw_r, clr_r;

  assign bus0.a_in = a_in_r;  assign bus1.a_in = a_in_r;  assign bus2.a_in = a_in_r;
  assign bus0.b_in = b_in_r;  assign bus1.b_in = b_in_r;  assign bus2.b_in = b_in_r;
  assign bus0.a_valid = av_r; assign bus1.a_valid = av_r; assign bus2.a_valid = av_r;
  assign bus0.load_weight = lw_r; assign bus1.load_weight = lw_r; assign bus2.load_weight = lw_r;
  assign bus0.swap_weight = sw_r; assign bus1.swap_weight = sw_r; assign bus2.swap_weight = sw_r;
  assign bus0.clr = clr_r;    assign bus1.clr = clr_r;    assign bus2.clr = clr_r;

  int n_chk = 0;
  int n_err = 0;

  // Stimulus for the next cycle
  int s_a[4];
  int s_b[4];
  bit s_av, s_lw, s_sw, s_clr;

  // Reference model state
  int     acc_w_c[3] = '{32, 20, 20};
  bit     sat_c[3]   = '{1'b1, 1'b1, 1'b0};
  longint m_acc[3][4];
  bit     m_sat[3][4];
  int     m_cnt;
  int     m_sh[4];
  int     m_ac[4];
  int     edge_n;

  typedef struct packed {
    logic [3:0][31:0] p;
    int               due;
  } beat_t;
  beat_t pend[$];

  typedef struct packed {
    logic [31:0]            a_out;
    logic                   avo;
    logic                   lwo;
    logic                   swo;
    logic [2:0][3:0][63:0]  acc;
    logic [2:0][3:0]        sat;
    logic [15:0]            cnt;
  } snap_t;
  snap_t exp_q[$];

  task automatic chk(string nm, logic signed [63:0] got, logic signed [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic logic signed [63:0] dut_acc(int k, int l);
    case (k)
      0:       dut_acc = 64'($signed(bus0.acc[l*32 +: 32]));
      1:       dut_acc = 64'($signed(bus1.acc[l*20 +: 20]));
      default: dut_acc = 64'($signed(bus2.acc[l*20 +: 20]));
    endcase
  endfunction

  function automatic logic [3:0] dut_sat(int k);
    case (k)
      0:       dut_sat = bus0.sat_flag;
      1:       dut_sat = bus1.sat_flag;
      default: dut_sat = bus2.sat_flag;
    endcase
  endfunction

  function automatic logic [15:0] dut_cnt(int k);
    case (k)
      0:       dut_cnt = bus0.beat_cnt;
      1:       dut_cnt = bus1.beat_cnt;
      default: dut_cnt = bus2.beat_cnt;
    endcase
  endfunction

  function automatic logic [34:0] dut_fwd(int k);
    case (k)
      0:       dut_fwd = {bus0.a_out, bus0.a_valid_out, bus0.load_weight_out, bus0.swap_weight_out};
      1:       dut_fwd = {bus1.a_out, bus1.a_valid_out, bus1.load_weight_out, bus1.swap_weight_out};
      default: dut_fwd = {bus2.a_out, bus2.a_valid_out, bus2.load_weight_out, bus2.swap_weight_out};
    endcase
  endfunction

  // Signed add into a w-bit accumulator: clamp or wrap on overflow.
  function automatic longint acc_model(longint acc, longint p, int w, bit sat, output bit ovf);
    longint hi, lo, sum, span;
    hi   = (longint'(1) <<< (w - 1)) - 1;
    lo   = -hi - 1;
    span = 2 * (hi + 1);
    sum  = acc + p;
    ovf  = (sum > hi) || (sum < lo);
    if (!ovf)     return sum;
    if (sat)      return (sum > hi) ? hi : lo;
    if (sum > hi) return sum - span;
    return sum + span;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 4; l++) begin
        m_acc[k][l] = 0;
        m_sat[k][l] = 1'b0;
      end
    for (int l = 0; l < 4; l++) begin
      m_sh[l] = 0;
      m_ac[l] = 0;
    end
    m_cnt = 0;
    pend.delete();
  endtask

  task automatic land(beat_t bt);
    bit ovf;
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 4; l++) begin
        m_acc[k][l] = acc_model(m_acc[k][l], longint'($signed(bt.p[l])), acc_w_c[k], sat_c[k],
                                ovf);
        if (ovf) m_sat[k][l] = 1'b1;
      end
    if (m_cnt < 65535) m_cnt++;
  endtask

  // One clock edge of the reference model, then queue the expected outputs
  task automatic model_edge();
    beat_t nb;
    snap_t s;
    edge_n++;
    for (int l = 0; l < 4; l++) nb.p[l] = 32'(s_a[l] * m_ac[l]);
    nb.due = edge_n + 1;
    if (s_clr) begin
      for (int k = 0; k < 3; k++)
        for (int l = 0; l < 4; l++) begin
          m_acc[k][l] = 0;
          m_sat[k][l] = 1'b0;
        end
      m_cnt = 0;
      pend.delete();
    end else begin
      while (pend.size() > 0 && pend[0].due == edge_n) land(pend.pop_front());
      if (s_av) pend.push_back(nb);
    end
    if (s_sw) for (int l = 0; l < 4; l++) m_ac[l] = m_sh[l];
    if (s_lw) for (int l = 0; l < 4; l++) m_sh[l] = s_b[l];
    for (int l = 0; l < 4; l++) s.a_out[l*8 +: 8] = 8'(s_a[l]);
    s.avo = s_av;
    s.lwo = s_lw;
    s.swo = s_sw;
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 4; l++) begin
        s.acc[k][l] = m_acc[k][l];
        s.sat[k][l] = m_sat[k][l];
      end
    s.cnt = 16'(m_cnt);
    exp_q.push_back(s);
  endtask

  task automatic drive();
    for (int l = 0; l < 4; l++) begin
      a_in_r[l*8 +: 8] = 8'(s_a[l]);
      b_in_r[l*8 +: 8] = 8'(s_b[l]);
    end
    av_r  = s_av;
    lw_r  = s_lw;
    sw_r  = s_sw;
    clr_r = s_clr;
  endtask

  task automatic set_idle();
    for (int l = 0; l < 4; l++) begin
      s_a[l] = 0;
      s_b[l] = 0;
    end
    s_av = 0; s_lw = 0; s_sw = 0; s_clr = 0;
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle();
    set_idle();
    step();
  endtask

  task automatic do_clr();
    set_idle();
    s_clr = 1;
    step();
  endtask

  task automatic load_all(int w, bit swap);
    set_idle();
    for (int l = 0; l < 4; l++) s_b[l] = w;
    s_lw = 1;
    s_sw = swap;
    step();
  endtask

  task automatic swap_only();
    set_idle();
    s_sw = 1;
    step();
  endtask

  task automatic beat_all(int a, bit swap);
    set_idle();
    for (int l = 0; l < 4; l++) s_a[l] = a;
    s_av = 1;
    s_sw = swap;
    step();
  endtask

  task automatic check_zero(string nm);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s fwd cfg%0d", nm, k), dut_fwd(k), 0);
      for (int l = 0; l < 4; l++) chk($sformatf("%s acc cfg%0d lane%0d", nm, k, l), dut_acc(k, l), 0);
      chk($sformatf("%s sat cfg%0d", nm, k), dut_sat(k), 0);
      chk($sformatf("%s cnt cfg%0d", nm, k), dut_cnt(k), 0);
    end
  endtask

  task automatic check_acc_all(string nm, int k, longint want);
    for (int l = 0; l < 4; l++) chk($sformatf("%s cfg%0d lane%0d", nm, k, l), dut_acc(k, l), want);
  endtask

  // Monitor: compare every instance against the expected snapshot for the last edge
  always @(negedge clk) begin
    snap_t e;
    if (rst_n === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("mon fwd cfg%0d", k), dut_fwd(k), {e.a_out, e.avo, e.lwo, e.swo});
        for (int l = 0; l < 4; l++)
          chk($sformatf("mon acc cfg%0d lane%0d", k, l), dut_acc(k, l), $signed(e.acc[k][l]));
        chk($sformatf("mon sat cfg%0d", k), dut_sat(k), e.sat[k]);
        chk($sformatf("mon cnt cfg%0d", k), dut_cnt(k), e.cnt);
      end
    end
  end

  initial begin
    int w1[4];
    int a1[4];
    rst_n  = 1'b0;
    edge_n = 0;
    set_idle();
    drive();
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single beat through distinct weights per lane
    w1 = '{10, -5, 127, -128};
    a1 = '{5, 4, 127, 127};
    set_idle();
    s_b = w1;
    s_lw = 1;
    step();
    swap_only();
    set_idle();
    s_a = a1;
    s_av = 1;
    step();
    idle();
    #1;
    chk("t1 acc lane0", dut_acc(0, 0), 50);
    chk("t1 acc lane1", dut_acc(0, 1), -20);
    chk("t1 acc lane2", dut_acc(0, 2), 16129);
    chk("t1 acc lane3", dut_acc(0, 3), -16256);
    chk("t1 cnt", dut_cnt(0), 1);
    chk("t1 sat", dut_sat(0), 0);

    // Swap mid-stream while the next bank was preloaded
    do_clr();
    load_all(2, 1'b0);
    swap_only();
    load_all(3, 1'b0);
    for (int i = 1; i <= 10; i++) beat_all(i, i == 5);
    idle();
    #1;
    check_acc_all("t2 acc", 0, 150);
    chk("t2 cnt", dut_cnt(0), 10);

    // Overflow: clamp high, wrap, then clamp low
    do_clr();
    load_all(127, 1'b0);
    swap_only();
    for (int i = 0; i < 33; i++) beat_all(127, 1'b0);
    idle();
    #1;
    check_acc_all("t3 sat hi", 1, 524287);
    chk("t3 sat hi flag", dut_sat(1), 4'hf);
    check_acc_all("t3 wrap", 2, -516319);
    chk("t3 wrap flag", dut_sat(2), 4'hf);
    check_acc_all("t3 wide", 0, 532257);
    chk("t3 wide flag", dut_sat(0), 0);
    do_clr();
    load_all(-128, 1'b0);
    swap_only();
    for (int i = 0; i < 33; i++) beat_all(127, 1'b0);
    idle();
    #1;
    check_acc_all("t3 sat lo", 1, -524288);
    chk("t3 sat lo flag", dut_sat(1), 4'hf);

    // clr with a product in flight and a beat in the same cycle
    beat_all(2, 1'b0);
    beat_all(3, 1'b0);
    set_idle();
    for (int l = 0; l < 4; l++) s_a[l] = 3;
    s_av = 1;
    s_clr = 1;
    step();
    idle();
    #1;
    check_acc_all("t5 acc after clr", 0, 0);
    chk("t5 sat cleared", dut_sat(1), 0);
    chk("t5 cnt cleared", dut_cnt(0), 0);
    beat_all(1, 1'b0);
    idle();
    #1;
    check_acc_all("t5 acc restart", 0, -128);
    chk("t5 cnt restart", dut_cnt(0), 1);

    // Forwarding without valid, load pulse, load+swap together
    do_clr();
    set_idle();
    for (int l = 0; l < 4; l++) s_a[l] = 42;
    step();
    #1;
    chk("t4 a_out", bus0.a_out, 32'h2a2a2a2a);
    check_acc_all("t4 acc hold", 0, 0);
    load_all(7, 1'b0);
    #1;
    chk("t4 load_out high", bus0.load_weight_out, 1);
    idle();
    #1;
    chk("t4 load_out low", bus0.load_weight_out, 0);
    load_all(9, 1'b1);
    beat_all(1, 1'b0);
    idle();
    #1;
    check_acc_all("t4 load+swap", 0, 7);

    // Random traffic, then positive-biased traffic that overflows the narrow lanes
    for (int i = 0; i < 200; i++) begin
      for (int l = 0; l < 4; l++) begin
        s_a[l] = int'($urandom_range(0, 255)) - 128;
        s_b[l] = int'($urandom_range(0, 255)) - 128;
      end
      s_av  = ($urandom_range(0, 9) < 6);
      s_lw  = ($urandom_range(0, 4) == 0);
      s_sw  = ($urandom_range(0, 9) == 0);
      s_clr = ($urandom_range(0, 49) == 0);
      step();
    end
    for (int i = 0; i < 150; i++) begin
      for (int l = 0; l < 4; l++) begin
        s_a[l] = int'($urandom_range(100, 127));
        s_b[l] = int'($urandom_range(100, 127));
      end
      s_av  = ($urandom_range(0, 9) < 8);
      s_lw  = ($urandom_range(0, 3) == 0);
      s_sw  = ($urandom_range(0, 7) == 0);
      s_clr = ($urandom_range(0, 99) == 0);
      step();
    end

    // Asynchronous reset between edges, mid-stream
    beat_all(5, 1'b0);
    beat_all(6, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid reset");
    model_reset();
    set_idle();
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    swap_only();
    beat_all(50, 1'b0);
    idle();
    #1;
    check_acc_all("t6 zero weights", 0, 0);
    chk("t6 cnt", dut_cnt(0), 1);

    @(negedge clk);
    #1;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
